// File: rtl/sseg_pkg.sv
// Shared constants, converter state type and helper functions for the 7-segment scan driver.
package sseg_pkg;

  // Active-low segment patterns, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {StIdle, StShift, StDone} conv_state_e;

  // ceil(w * log10(2)) using a fixed-point log10(2) of 0.30103.
  function automatic int unsigned bcd_nibbles(int unsigned w);
    int unsigned n;
    n = (w * 30103 + 99999) / 100000;
    return (n == 0) ? 1 : n;
  endfunction

  function automatic logic [6:0] seg_decode(logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sseg_scan_driver_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock, start/done handshake.
module bin2bcd_seq import sseg_pkg::*; #(
  parameter int unsigned VAL_W = 19,
  parameter int unsigned BCD_N = bcd_nibbles(VAL_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [VAL_W-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic [4*BCD_N-1:0] bcd
);

  localparam int unsigned CW = $clog2(VAL_W + 1);

  conv_state_e        state;
  logic [VAL_W-1:0]   sr;
  logic [CW-1:0]      cnt;
  logic [4*BCD_N-1:0] adj;

  // Add 3 to every nibble >= 5 ahead of the shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < int'(BCD_N); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Converter FSM; bcd holds the finished result from DONE until the next capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= StIdle;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      sr    <= '0;
      bcd   <= '0;
    end else if (abort) begin
      state <= StIdle;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            sr    <= bin;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StShift;
          end
        end
        StShift: begin
          {bcd, sr} <= {adj, sr} << 1;
          cnt       <= cnt + 1'b1;
          if (cnt == CW'(VAL_W - 1)) begin
            busy  <= 1'b0;
            state <= StDone;
          end
        end
        StDone: begin
          done  <= 1'b1;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed common-anode 7-segment driver: decimal (double-dabble) or hex display, LZ blanking.
module sseg_scan_driver import sseg_pkg::*; #(
  parameter int unsigned N_DIGITS = 6,
  parameter int unsigned VAL_W    = 19,
  parameter int unsigned SCAN_DIV = 65536
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VAL_W-1:0]    value,
  input  logic                hex_mode,
  input  logic                lz_blank,
  input  logic [N_DIGITS-1:0] dp,
  output logic [6:0]          seg,
  output logic                seg_dp,
  output logic [N_DIGITS-1:0] an,
  output logic                ovf,
  output logic                busy
);

  localparam int unsigned BCD_N = bcd_nibbles(VAL_W);
  localparam int unsigned EXT_N = (BCD_N > N_DIGITS) ? BCD_N : N_DIGITS;
  localparam int unsigned HEX_W = (VAL_W > 4 * N_DIGITS) ? VAL_W : 4 * N_DIGITS;
  localparam int unsigned PW    = $clog2(SCAN_DIV);
  localparam int unsigned IW    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [PW-1:0]         presc;
  logic                  tick;
  logic [IW-1:0]         idx, idx_nxt;
  logic [4*N_DIGITS-1:0] digits;
  logic [4*BCD_N-1:0]    bcd;
  logic [4*EXT_N-1:0]    bcd_ext;
  logic [HEX_W-1:0]      hex_ext;
  logic                  conv_done, bcd_ovf, hex_ovf;
  logic [N_DIGITS-1:0]   blank, an_nxt;
  logic                  zero_above;
  logic [3:0]            cur;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  bin2bcd_seq #(
    .VAL_W(VAL_W),
    .BCD_N(BCD_N)
  ) u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .start(!hex_mode),
    .abort(hex_mode),
    .bin  (value),
    .busy (busy),
    .done (conv_done),
    .bcd  (bcd)
  );

  assign tick = (presc == PW'(SCAN_DIV - 1));

  // Scan prescaler, wraps at SCAN_DIV-1.
  always_ff @(posedge clk) begin
    if (!rst || tick) presc <= '0;
    else              presc <= presc + 1'b1;
  end

  // Widen converter and raw value so overflow is just "any bit above the visible digits".
  always_comb begin
    bcd_ext                = '0;
    bcd_ext[4*BCD_N-1:0]   = bcd;
    hex_ext                = '0;
    hex_ext[VAL_W-1:0]     = value;
    bcd_ovf                = 1'b0;
    for (int unsigned i = N_DIGITS; i < EXT_N; i++) bcd_ovf = bcd_ovf | (|bcd_ext[4*i +: 4]);
    hex_ovf                = 1'b0;
    for (int unsigned i = 4 * N_DIGITS; i < HEX_W; i++) hex_ovf = hex_ovf | hex_ext[i];
  end

  // Display register: raw nibbles every cycle in hex mode, else the finished BCD result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      digits <= '0;
      ovf    <= 1'b0;
    end else if (hex_mode) begin
      digits <= hex_ext[4*N_DIGITS-1:0];
      ovf    <= hex_ovf;
    end else if (conv_done) begin
      digits <= bcd_ext[4*N_DIGITS-1:0];
      ovf    <= bcd_ovf;
    end
  end

  // Leading-zero mask and pattern for the digit about to be scanned out.
  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
      zero_above = zero_above && (digits[4*k +: 4] == 4'd0);
      blank[k]   = lz_blank && (k != 0) && zero_above;
    end
    cur    = digits[4*idx +: 4];
    an_nxt = '1;
    an_nxt[idx] = 1'b0;
    if (ovf) begin
      seg_nxt = SEG_DASH;
      dp_nxt  = 1'b1;
    end else begin
      seg_nxt = blank[idx] ? SEG_BLANK : seg_decode(cur);
      dp_nxt  = ~dp[idx];
    end
    idx_nxt = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
  end

  // idx names the next slot to show, so the first tick after reset selects digit 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx    <= '0;
      an     <= '1;
      seg    <= SEG_BLANK;
      seg_dp <= 1'b1;
    end else if (tick) begin
      idx    <= idx_nxt;
      an     <= an_nxt;
      seg    <= seg_nxt;
      seg_dp <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: 6-digit/19-bit instance checked against a behavioural model every
// cycle, plus a 4-digit/17-bit instance for decimal overflow, with literal per-digit expectations.
module tb_sseg_scan_driver;

  localparam int N6 = 6, W6 = 19, N4 = 4, W4 = 17, DIV = 4;

  logic clk = 1'b0, rst = 1'b0, hex_mode = 1'b0, lz_blank = 1'b0;
  logic [W6-1:0] value6 = '0;
  logic [N6-1:0] dp6 = '0;
  logic [W4-1:0] value4 = '0;
  logic [N4-1:0] dp4 = '0;
  logic [6:0]    seg6, seg4;
  logic          segdp6, segdp4, ovf6, ovf4, busy6, busy4;
  logic [N6-1:0] an6;
  logic [N4-1:0] an4;

  int n_checks = 0, n_fail = 0;
  logic chk_on = 1'b0, model_on = 1'b0;
  int unsigned since_rst = 0;

  // Active-high gfedcba patterns for 0..F.
  logic [6:0] lit_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [6:0] cap6 [N6];
  logic       capdp6 [N6];
  logic [6:0] cap4 [N4];
  logic [6:0] exp6 [N6];
  logic       bb [30];
  logic       ov4 [30];
  logic [N6-1:0] an_rec [4];

  always #5 clk = ~clk;

  sseg_scan_driver #(.N_DIGITS(N6), .VAL_W(W6), .SCAN_DIV(DIV)) dut6 (
    .clk(clk), .rst(rst), .value(value6), .hex_mode(hex_mode), .lz_blank(lz_blank), .dp(dp6),
    .seg(seg6), .seg_dp(segdp6), .an(an6), .ovf(ovf6), .busy(busy6)
  );

  sseg_scan_driver #(.N_DIGITS(N4), .VAL_W(W4), .SCAN_DIV(DIV)) dut4 (
    .clk(clk), .rst(rst), .value(value4), .hex_mode(hex_mode), .lz_blank(lz_blank), .dp(dp4),
    .seg(seg4), .seg_dp(segdp4), .an(an4), .ovf(ovf4), .busy(busy4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: what the 6-digit display must show for the current inputs.
  function automatic logic model_ovf();
    int unsigned v;
    v = 32'(value6);
    if (hex_mode) return (v >> (4 * N6)) != 0;
    return v >= 1000000;
  endfunction

  function automatic logic [7:0] model_slot(int k);  // {seg_dp, seg}
    int unsigned v, p;
    int unsigned d [N6];
    logic zero_run;
    v = 32'(value6);
    p = 1;
    for (int j = 0; j < N6; j++) begin
      if (hex_mode) d[j] = (v >> (4 * j)) & 32'd15;
      else begin
        d[j] = (v / p) % 10;
        p    = p * 10;
      end
    end
    if (model_ovf()) return {1'b1, ~7'h40};
    zero_run = 1'b1;
    for (int j = N6 - 1; j >= k; j--) zero_run = zero_run && (d[j] == 0);
    if (lz_blank && k > 0 && zero_run) return {~dp6[k], 7'h7F};
    return {~dp6[k], ~lit_tab[d[k]]};
  endfunction

  // Posedges since the last reset edge; scan position follows from it arithmetically.
  always @(posedge clk) since_rst <= rst ? since_rst + 1 : 0;

  int unsigned ticks, slot;
  logic [N6-1:0] exp_an;
  logic [7:0] exp_slot;

  always @(negedge clk) begin
    if (chk_on) begin
      ticks = since_rst / DIV;
      if (ticks == 0) begin
        check("an_pre_tick", 32'(an6), 32'h3F);
        check("seg_pre_tick", 32'(seg6), 32'h7F);
        check("segdp_pre_tick", 32'(segdp6), 32'd1);
      end else begin
        slot = (ticks - 1) % N6;
        exp_an = '1;
        exp_an[slot] = 1'b0;
        check("an_scan", 32'(an6), 32'(exp_an));
        if (model_on) begin
          exp_slot = model_slot(int'(slot));
          check("seg_model", 32'(seg6), 32'(exp_slot[6:0]));
          check("segdp_model", 32'(segdp6), 32'(exp_slot[7]));
          check("ovf_model", 32'(ovf6), 32'(model_ovf()));
          if (hex_mode) check("busy_hex", 32'(busy6), 32'd0);
        end
      end
    end
  end

  task automatic capture();
    for (int i = 0; i < N6; i++) begin cap6[i] = 7'bx; capdp6[i] = 1'bx; end
    for (int i = 0; i < N4; i++) cap4[i] = 7'bx;
    repeat (2 * N6 * DIV) begin
      @(negedge clk);
      for (int i = 0; i < N6; i++) if (an6 == ~(6'b1 << i)) begin
        cap6[i]   = seg6;
        capdp6[i] = segdp6;
      end
      for (int i = 0; i < N4; i++) if (an4 == ~(4'b1 << i)) cap4[i] = seg4;
    end
  endtask

  task automatic settle();
    repeat (80) @(negedge clk);
    model_on = 1'b1;
    capture();
  endtask

  task automatic cmp_digits6(input string tag);
    for (int i = 0; i < N6; i++) check($sformatf("%s_d%0d", tag, i), 32'(cap6[i]), 32'(exp6[i]));
  endtask

  task automatic wait_busy();
    int i;
    i = 0;
    while (busy6 !== 1'b1 && i < 40) begin @(negedge clk); i++; end
    check("busy_start", 32'(busy6), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    value6 = 19'd123456;
    value4 = 17'd12345;
    repeat (3) @(negedge clk);
    check("rst_an6", 32'(an6), 32'h3F);
    check("rst_seg6", 32'(seg6), 32'h7F);
    check("rst_segdp6", 32'(segdp6), 32'd1);
    check("rst_busy6", 32'(busy6), 32'd0);
    check("rst_ovf6", 32'(ovf6), 32'd0);
    check("rst_an4", 32'(an4), 32'hF);
    chk_on = 1'b1;

    // Conversion timing straight out of reset.
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bb[i]  = busy6;
      ov4[i] = ovf4;
    end
    begin
      int ones;
      ones = 0;
      for (int i = 0; i <= 20; i++) if (bb[i] === 1'b1) ones++;
      check("busy_len", 32'(ones), 32'd19);
    end
    check("busy_first", 32'(bb[0]), 32'd1);
    check("busy_drop", 32'(bb[19]), 32'd0);
    check("busy_restart", 32'(bb[21]), 32'd1);
    check("ovf4_before_done", 32'(ov4[18]), 32'd0);
    check("ovf4_after_done", 32'(ov4[19]), 32'd1);

    settle();
    exp6 = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    cmp_digits6("v123456");
    for (int i = 0; i < N4; i++) check($sformatf("ovf4_dash_d%0d", i), 32'(cap4[i]), 32'h3F);
    check("ovf4_12345", 32'(ovf4), 32'd1);

    model_on = 1'b0;
    value6 = 19'd42;
    lz_blank = 1'b1;
    value4 = 17'd9999;
    settle();
    exp6 = '{7'h24, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    cmp_digits6("v42_lz");
    for (int i = 0; i < N4; i++) check($sformatf("v9999_d%0d", i), 32'(cap4[i]), 32'h10);
    check("ovf4_9999", 32'(ovf4), 32'd0);

    model_on = 1'b0;
    lz_blank = 1'b0;
    settle();
    exp6 = '{7'h24, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40};
    cmp_digits6("v42_nolz");

    model_on = 1'b0;
    value6 = '0;
    lz_blank = 1'b1;
    dp6 = 6'b000001;
    settle();
    exp6 = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    cmp_digits6("v0_lz");
    check("v0_dp0", 32'(capdp6[0]), 32'd0);
    for (int i = 1; i < N6; i++) check($sformatf("v0_dp%0d", i), 32'(capdp6[i]), 32'd1);

    // Hex mode entered mid-conversion.
    wait_busy();
    repeat (5) @(negedge clk);
    check("busy_mid_shift", 32'(busy6), 32'd1);
    model_on = 1'b0;
    value6 = 19'h7ABCD;
    value4 = 17'h1ABCD;
    hex_mode = 1'b1;
    lz_blank = 1'b0;
    dp6 = '0;
    @(negedge clk);
    check("hex_abort_busy6", 32'(busy6), 32'd0);
    check("hex_busy4", 32'(busy4), 32'd0);
    @(negedge clk);
    check("hex_ovf4", 32'(ovf4), 32'd1);
    settle();
    exp6 = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h78, 7'h40};
    cmp_digits6("hex");
    for (int i = 0; i < N4; i++) check($sformatf("hex4_dash_d%0d", i), 32'(cap4[i]), 32'h3F);

    // Back to decimal, then reset mid-conversion and mid-scan.
    model_on = 1'b0;
    value6 = 19'd123456;
    value4 = 17'd12345;
    hex_mode = 1'b0;
    @(negedge clk);
    check("dec_restart_busy", 32'(busy6), 32'd1);
    repeat (6) @(negedge clk);
    check("pre_rst_busy", 32'(busy6), 32'd1);
    check("pre_rst_ovf4", 32'(ovf4), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_an6", 32'(an6), 32'h3F);
    check("mid_rst_seg6", 32'(seg6), 32'h7F);
    check("mid_rst_segdp6", 32'(segdp6), 32'd1);
    check("mid_rst_busy6", 32'(busy6), 32'd0);
    check("mid_rst_ovf6", 32'(ovf6), 32'd0);
    check("mid_rst_ovf4", 32'(ovf4), 32'd0);
    check("mid_rst_an4", 32'(an4), 32'hF);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      an_rec[i] = an6;
    end
    check("post_rst_an_c1", 32'(an_rec[0]), 32'h3F);
    check("post_rst_an_c3", 32'(an_rec[2]), 32'h3F);
    check("post_rst_first_tick", 32'(an_rec[3]), 32'h3E);
    settle();
    exp6 = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    cmp_digits6("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Parametrised multiplexed 7-segment driver for N_DIGITS common-anode digits.
- Converts an unsigned binary value to BCD with a sequential double-dabble engine, or shows raw hex nibbles in hex mode.
- Adds leading-zero blanking, per-digit decimal points and overflow indication.
- Scan rate comes from a clock-enable prescaler on clk; no derived clocks. Sits between datapath counters and board pins.

Parameters:
- N_DIGITS, 6, number of digits/anodes (1..8).
- VAL_W, 19, width of the binary input value.
- SCAN_DIV, 65536, clk cycles per digit slot (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- value  in  VAL_W  unsigned number to display
- hex_mode  in  1  1: show value as hex nibbles; 0: decimal
- lz_blank  in  1  1: blank leading zeros
- dp  in  N_DIGITS  decimal point per digit, 1 = lit (bit 0 = rightmost digit)
- seg  out  7  segments, active-low; seg[0]=a ... seg[6]=g
- seg_dp  out  1  decimal point segment, active-low
- an  out  N_DIGITS  anodes, active-low, one-hot-low while scanning
- ovf  out  1  decimal value exceeds 10^N_DIGITS-1
- busy  out  1  conversion in progress

Behaviour:
- Reset (rst==0 at posedge clk): seg=7'h7F, seg_dp=1, an=all ones, ovf=0, busy=0, prescaler=0, digit index=0, digit register=all zero. Reset mid-conversion aborts the conversion; the display register keeps no partial result.
- Converter FSM IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE, hex_mode=0: capture value, busy=1, go to SHIFT.
  - SHIFT: VAL_W double-dabble iterations, one per clk: add 3 to every BCD nibble >=5, then shift left one bit.
  - DONE: atomically copy the BCD nibbles into the digit register, update ovf, busy=0.
  - Latency from capture to display register update: VAL_W+2 cycles. Conversion then restarts continuously; value changes during SHIFT are seen on the next pass.
- BCD width: 4*ceil(VAL_W*log10(2)) nibbles internally. ovf=1 when any nibble above index N_DIGITS-1 is non-zero. While ovf=1, every digit shows a dash (g only: seg=7'h3F) and dp is ignored.
- Hex mode: the digit register loads value nibbles directly every cycle, zero-extended to 4*N_DIGITS bits. ovf=1 if bits above 4*N_DIGITS-1 are non-zero. The FSM is held in IDLE with busy=0. Toggling hex_mode mid-SHIFT aborts the conversion, returns to IDLE and discards the result.
- Prescaler: counts 0..SCAN_DIV-1 and wraps; tick is asserted on the count SCAN_DIV-1.
- On tick:
  - Digit index increments, wrapping N_DIGITS-1 -> 0.
  - an, seg and seg_dp register the new digit; an has a single 0 at the index bit.
  - A digit change therefore appears one cycle after tick.
- Leading-zero blanking: with lz_blank=1, digit k>0 is blank (seg=7'h7F) if it and all higher digits are 0. Digit 0 is never blanked. dp still lights on a blanked digit. The anode stays driven.
- Segment decode covers 0-F (hex); decimal digits are never >9.

Decomposition:
- Package sseg_pkg: 7-bit active-low constants SEG_0..SEG_F, SEG_DASH, SEG_BLANK; converter state enum; function computing the BCD nibble count from VAL_W.
- Sub-module bin2bcd_seq: the double-dabble FSM with start/done handshake, parametrised by VAL_W.
- Segment decode is a function in sseg_pkg, not a module.

Test Plan:
- N_DIGITS=6, SCAN_DIV=4, value=123456, hex_mode=0: busy for 19 cycles after capture; scanned digits read 6,5,4,3,2,1 with an=111110,111101,...,011111, one slot per 4 clks.
- value=42, lz_blank=1: digits 5..2 show seg=7'h7F, digit1=SEG_4, digit0=SEG_2. With lz_blank=0, digits 5..2 show SEG_0.
- value=0, lz_blank=1, dp=6'b000001: only digit 0 shows SEG_0 with seg_dp=0; all other digits blank with seg_dp=1.
- N_DIGITS=4, VAL_W=17, value=12345: ovf=1 after DONE; all digits SEG_DASH. Then value=9999: ovf=0 and 9,9,9,9 are shown.
- hex_mode=1, value=19'h7ABCD, N_DIGITS=6: digits D,C,B,A,7,0 appear immediately with busy=0. Switching to hex_mode=1 mid-SHIFT returns the FSM to IDLE.
- rst=0 asserted mid-SHIFT and mid-scan: next cycle an=all ones, seg=7'h7F, busy=0, ovf=0; after release the first tick selects digit 0 after SCAN_DIV cycles.
